// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue_if
//  Brief    : Fetch/decode handshake bundle for the instruction fetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if #(
    parameter int AW = 2
);
    logic          start_i;
    logic          push_i;
    logic [31:0]   pc_i;
    logic [31:0]   instr_i;
    logic          pop_i;
    logic          flush_i;
    logic [31:0]   pc_o;
    logic [31:0]   instr_o;
    logic          valid_o;
    logic          empty_o;
    logic          full_o;
    logic [AW:0]   count_o;

    modport master (
        output start_i, push_i, pc_i, instr_i, pop_i, flush_i,
        input  pc_o, instr_o, valid_o, empty_o, full_o, count_o
    );

    modport slave (
        input  start_i, push_i, pc_i, instr_i, pop_i, flush_i,
        output pc_o, instr_o, valid_o, empty_o, full_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Brief    : In-order {pc, instr} queue between fetch and IF/ID decode,
//             show-ahead head with NOP bubble when empty, flush on redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    if_fetch_queue_if.slave  bus
);

    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    logic [63:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_run;
    logic [DEPTH-1:0] w_we;
    logic [63:0]      w_head;

    assign w_full  = (r_cnt == c_CNT_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_run   = bus.start_i & ~bus.flush_i;

    // Acceptance is judged on the pre-edge count, so a full queue drops a
    // push even when a pop frees a slot in the same cycle.
    assign w_push  = w_run & bus.push_i & ~w_full;
    assign w_pop   = w_run & bus.pop_i  & ~w_empty;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign w_we[gi] = w_push & (r_wp == AW'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= {bus.pc_i, bus.instr_i};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (bus.start_i) begin
            if (bus.flush_i) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rp <= r_rp + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                    2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Show-ahead head; masked to a NOP bubble so stale storage never leaks.
    assign w_head      = r_mem[r_rp];
    assign bus.pc_o    = w_empty ? 32'h0 : w_head[63:32];
    assign bus.instr_o = w_empty ? 32'h0 : w_head[31:0];
    assign bus.valid_o = ~w_empty;
    assign bus.empty_o = w_empty;
    assign bus.full_o  = w_full;
    assign bus.count_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Brief    : Directed self-checking bench for if_fetch_queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    if_fetch_queue_if #(.AW(2)) bus ();

    if_fetch_queue #(.DEPTH(4), .AW(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of stimulus, advance past the edge, land at the sample point.
    task automatic cyc(input logic push, input logic [31:0] pc, input logic [31:0] instr,
                       input logic pop, input logic flush);
        bus.push_i  = push;
        bus.pc_i    = pc;
        bus.instr_i = instr;
        bus.pop_i   = pop;
        bus.flush_i = flush;
        @(posedge clk_i);
        #1;
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic test_reset;
        bus.start_i = 1'b1;
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.flush_i = 1'b0;
        bus.pc_i    = '0;
        bus.instr_i = '0;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_total++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid_o); else n_pass++;
        n_total++; if (bus.instr_o !== 32'h0) $display("FAIL reset_instr got=%h exp=0", bus.instr_o); else n_pass++;
        n_total++; if (bus.pc_o !== 32'h0) $display("FAIL reset_pc got=%h exp=0", bus.pc_o); else n_pass++;
        n_total++; if (bus.empty_o !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.empty_o); else n_pass++;
        n_total++; if (bus.full_o !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full_o); else n_pass++;
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", bus.count_o); else n_pass++;
    endtask

    task automatic test_fill_overflow;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 32'(4*k), 32'(32'hA0 + k), 1'b0, 1'b0);
            n_total++; if (bus.count_o !== 3'(k+1)) $display("FAIL fill_count%0d got=%0d exp=%0d", k, bus.count_o, k+1); else n_pass++;
            n_total++; if (bus.full_o !== (k == 3)) $display("FAIL fill_full%0d got=%b exp=%b", k, bus.full_o, (k == 3)); else n_pass++;
        end
        cyc(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
        n_total++; if (bus.full_o !== 1'b1) $display("FAIL ovf_full got=%b exp=1", bus.full_o); else n_pass++;
        n_total++; if (bus.count_o !== 3'd4) $display("FAIL ovf_count got=%0d exp=4", bus.count_o); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++; if (bus.pc_o !== 32'(4*k)) $display("FAIL drain_pc%0d got=%h exp=%h", k, bus.pc_o, 4*k); else n_pass++;
            n_total++; if (bus.instr_o !== 32'(32'hA0 + k)) $display("FAIL drain_instr%0d got=%h exp=%h", k, bus.instr_o, 32'hA0 + k); else n_pass++;
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            if (k == 0) begin
                n_total++; if (bus.full_o !== 1'b0) $display("FAIL unfull got=%b exp=0", bus.full_o); else n_pass++;
            end
        end
        n_total++; if (bus.empty_o !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.empty_o); else n_pass++;
        n_total++; if (bus.instr_o !== 32'h0) $display("FAIL drain_nop got=%h exp=0", bus.instr_o); else n_pass++;
    endtask

    task automatic test_wrap;
        cyc(1'b1, 32'h100, 32'hB100, 1'b0, 1'b0);
        n_total++; if (bus.pc_o !== 32'h100 || bus.valid_o !== 1'b1) $display("FAIL wrap_latency pc=%h valid=%b exp pc=100 valid=1", bus.pc_o, bus.valid_o); else n_pass++;
        cyc(1'b1, 32'h104, 32'hB104, 1'b0, 1'b0);
        for (int k = 2; k < 12; k++) begin
            n_total++; if (bus.pc_o !== 32'h100 + 32'(4*(k-2))) $display("FAIL wrap_pc%0d got=%h exp=%h", k, bus.pc_o, 32'h100 + 4*(k-2)); else n_pass++;
            cyc(1'b1, 32'h100 + 32'(4*k), 32'hB100 + 32'(4*k), 1'b1, 1'b0);
            n_total++; if (bus.count_o !== 3'd2) $display("FAIL wrap_count%0d got=%0d exp=2", k, bus.count_o); else n_pass++;
        end
        n_total++; if (bus.pc_o !== 32'h128) $display("FAIL wrap_tail0 got=%h exp=128", bus.pc_o); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_total++; if (bus.pc_o !== 32'h12C || bus.instr_o !== 32'hB12C) $display("FAIL wrap_tail1 pc=%h instr=%h exp 12c/b12c", bus.pc_o, bus.instr_o); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_total++; if (bus.empty_o !== 1'b1) $display("FAIL wrap_empty got=%b exp=1", bus.empty_o); else n_pass++;
    endtask

    task automatic test_flush;
        cyc(1'b1, 32'h20, 32'hC20, 1'b0, 1'b0);
        cyc(1'b1, 32'h24, 32'hC24, 1'b0, 1'b0);
        cyc(1'b1, 32'h28, 32'hC28, 1'b0, 1'b0);
        n_total++; if (bus.count_o !== 3'd3) $display("FAIL flush_pre got=%0d exp=3", bus.count_o); else n_pass++;
        cyc(1'b1, 32'h40, 32'hC40, 1'b1, 1'b1);
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL flush_count got=%0d exp=0", bus.count_o); else n_pass++;
        n_total++; if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0) $display("FAIL flush_head valid=%b instr=%h exp 0/0", bus.valid_o, bus.instr_o); else n_pass++;
        cyc(1'b1, 32'h80, 32'hC80, 1'b0, 1'b0);
        n_total++; if (bus.pc_o !== 32'h80 || bus.valid_o !== 1'b1 || bus.count_o !== 3'd1) $display("FAIL flush_repush pc=%h valid=%b cnt=%0d exp 80/1/1", bus.pc_o, bus.valid_o, bus.count_o); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_freeze;
        cyc(1'b1, 32'h200, 32'hD200, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'hD204, 1'b0, 1'b0);
        bus.start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h208, 32'hD208, 1'b1, (k == 1));
            n_total++; if (bus.count_o !== 3'd2 || bus.pc_o !== 32'h200) $display("FAIL freeze%0d cnt=%0d pc=%h exp 2/200", k, bus.count_o, bus.pc_o); else n_pass++;
        end
        bus.start_i = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_total++; if (bus.count_o !== 3'd1 || bus.pc_o !== 32'h204) $display("FAIL resume cnt=%0d pc=%h exp 1/204", bus.count_o, bus.pc_o); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_total++; if (bus.empty_o !== 1'b1) $display("FAIL resume_empty got=%b exp=1", bus.empty_o); else n_pass++;
    endtask

    task automatic test_edges;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_total++; if (bus.count_o !== 3'd0) $display("FAIL pop_empty got=%0d exp=0", bus.count_o); else n_pass++;
        cyc(1'b1, 32'h500, 32'hE500, 1'b1, 1'b0);
        n_total++; if (bus.count_o !== 3'd1 || bus.pc_o !== 32'h500) $display("FAIL pushpop_empty cnt=%0d pc=%h exp 1/500", bus.count_o, bus.pc_o); else n_pass++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'h300 + 32'(4*k), 32'hE300 + 32'(4*k), 1'b0, 1'b0);
        cyc(1'b1, 32'h310, 32'hE310, 1'b1, 1'b0);
        n_total++; if (bus.count_o !== 3'd3 || bus.full_o !== 1'b0) $display("FAIL full_pushpop cnt=%0d full=%b exp 3/0", bus.count_o, bus.full_o); else n_pass++;
        for (int k = 1; k < 4; k++) begin
            n_total++; if (bus.pc_o !== 32'h300 + 32'(4*k)) $display("FAIL full_seq%0d got=%h exp=%h", k, bus.pc_o, 32'h300 + 4*k); else n_pass++;
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        n_total++; if (bus.empty_o !== 1'b1 || bus.pc_o !== 32'h0) $display("FAIL full_dropped empty=%b pc=%h exp 1/0", bus.empty_o, bus.pc_o); else n_pass++;
        cyc(1'b1, 32'h600, 32'hE600, 1'b0, 1'b0);
        bus.push_i = 1'b1; bus.pc_i = 32'h604; bus.instr_i = 32'hE604;
        #2 rst_i = 1'b0;
        #1;
        n_total++; if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h0 || bus.count_o !== 3'd0)
            $display("FAIL async_reset valid=%b pc=%h instr=%h cnt=%0d exp all 0", bus.valid_o, bus.pc_o, bus.instr_o, bus.count_o);
        else n_pass++;
        bus.push_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_total++; if (bus.empty_o !== 1'b1) $display("FAIL post_reset_empty got=%b exp=1", bus.empty_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_flush();
        test_freeze();
        test_edges();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
